mp_coeff_loader: RTL and testbench
==================================

Name: mp_coeff_loader

Overview:
- Write-side initiator for the MP LUT coefficient port; the DPD core is the receiver.
- Accepts a stream of 32-bit LUT coefficient words on the AXI clock domain.
- Drives `coeff_i`, `coeff_addr_i` and `coeff_en_i` of the MP LUT wrapper with sequential byte addresses.
- Holds DPD bypassed (`wdpd_o` low) for the whole update. Checks frame length and reports completion or error.

Parameters:
- M, 3, memory depth of the MP model; the LUT holds M+1 tables.
- RESOLUTION, 4096, entries per table.
- DATA_WIDTH, 32, coefficient word width (I and Q packed).
- N_WORDS, RESOLUTION*(M+1), words per complete load; derived, not overridable.
- ADDR_WIDTH, $clog2(N_WORDS)+2, byte address width.

Ports:
- AXI_clk_i  in  1  AXI clock; the only clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- start_i  in  1  single-cycle pulse; arms a new load.
- abort_i  in  1  single-cycle pulse; cancels a load in progress.
- dpd_en_i  in  1  software request to enable DPD once a load is done.
- s_tdata_i  in  DATA_WIDTH  coefficient word.
- s_tvalid_i  in  1  stream valid.
- s_tlast_i  in  1  marks the last word of the frame.
- s_tready_o  out  1  stream ready.
- coeff_o  out  DATA_WIDTH  coefficient to the LUT.
- coeff_addr_o  out  ADDR_WIDTH  byte address: {word_index, 2'b00}.
- coeff_en_o  out  1  LUT write strobe.
- wdpd_o  out  1  DPD enable to the wrapper.
- busy_o  out  1  high in LOAD.
- done_o  out  1  sticky load complete.
- err_o  out  1  sticky length/tlast error.
- word_cnt_o  out  $clog2(N_WORDS+1)  number of words accepted in the current load.

Behaviour:
- Reset values:
  - FSM is in IDLE.
  - All outputs are 0, including `s_tready_o` and `wdpd_o`.
  - Reset asserted mid-load aborts the load immediately. The LUT keeps whatever words were already written.
- States: IDLE, LOAD, DONE, ERR.
- Transitions:
  - IDLE/DONE/ERR -> LOAD on `start_i`. Entering LOAD clears `word_cnt`, `done_o` and `err_o`.
  - LOAD -> DONE when the accepted word has index N_WORDS-1 and `s_tlast_i`=1.
  - LOAD -> ERR when `s_tlast_i`=1 at index < N_WORDS-1 (early tlast).
  - LOAD -> ERR when index = N_WORDS-1 with `s_tlast_i`=0 (missing tlast).
  - LOAD -> ERR on `abort_i`.
  - `start_i` while in LOAD is ignored.
  - `abort_i` and `start_i` in the same cycle: abort wins.
  - `abort_i` outside LOAD is ignored.
- Handshake:
  - `s_tready_o` = 1 only in LOAD; it is registered and set on entry to LOAD.
  - A word is accepted when `s_tvalid_i` & `s_tready_o`. There is no backpressure from the LUT, so every accepted word is written.
  - `s_tready_o` drops in the cycle after the final or error word.
- Write latency: one cycle. A word accepted in cycle t produces, in cycle t+1:
  - `coeff_en_o` = 1;
  - `coeff_o` = the accepted data;
  - `coeff_addr_o` = {index, 2'b00}.
  - With continuous valid this is one write per clock, in order.
- `coeff_en_o` is 0 in every cycle without an accepted word. `coeff_o` and `coeff_addr_o` hold their last value.
- The word that triggers ERR is still written to the LUT.
- Index handling: the index counter wraps only by re-entering LOAD. No words are accepted beyond N_WORDS-1.
- `word_cnt_o` increments on every accept. It holds its value in DONE/ERR until the next start.
- `wdpd_o`:
  - forced 0 in LOAD and ERR;
  - in DONE equals `dpd_en_i`, registered with 1-cycle latency;
  - in IDLE after reset it is 0, regardless of `dpd_en_i`.
- `busy_o` = (state == LOAD), registered.

Decomposition:
- Package mp_pkg holds:
  - the state enum for the FSM;
  - constants M, RESOLUTION and N_WORDS, shared with the MP LUT wrapper and the benches;
  - an `ADDR_LSB` = 2 constant for byte addressing.
- No sub-module: a single FSM with the index counter and output registers.

Test Plan:
- Nominal load:
  - Stimulus: reset, start, then 16384 words with data = index and tlast on the final word, continuous valid.
  - Response: 16384 `coeff_en_o` pulses on consecutive cycles, addresses 0x0 to 0xFFFC in steps of 4, each `coeff_o` = index; then `done_o`=1, `err_o`=0, `word_cnt_o`=16384.
- Early tlast:
  - Stimulus: tlast on word 100.
  - Response: word 100 written at address 0x190; next cycle `err_o`=1, `s_tready_o`=0, `wdpd_o`=0, `word_cnt_o`=101.
- Missing tlast:
  - Stimulus: 16384 words, none with tlast.
  - Response: `err_o`=1 after word 16383, `done_o`=0, no further writes.
- Gapped valid plus abort:
  - Stimulus: valid toggled every other cycle, `abort_i` pulsed after 50 words together with `start_i`.
  - Response: exactly 50 writes, then ERR (abort wins), `s_tready_o` low.
- DPD gating:
  - Stimulus: hold `dpd_en_i`=1 throughout, perform a nominal load, then a second start.
  - Response: `wdpd_o` is 0 during load 1; goes to 1 one cycle after DONE; returns to 0 in the cycle after the second start.
- Async reset:
  - Stimulus: drop `reset_n_i` mid-load, between clock edges.
  - Response: all outputs 0 immediately, with no clock edge required; state IDLE after release.

Source files
------------

// File: rtl/mp_pkg.sv
// -----------------------------------------------------------------------------
// mp_pkg
// Constants and types shared by the MP LUT coefficient loader, the MP LUT
// wrapper and the benches.
//   M          : memory depth of the MP model (the LUT holds M+1 tables)
//   RESOLUTION : entries per table
//   N_WORDS    : coefficient words in one complete load
//   ADDR_LSB   : byte-address shift (one 32-bit word = 4 bytes)
//   ld_state_e : loader FSM states
// -----------------------------------------------------------------------------
package mp_pkg;

    localparam int M          = 3;
    localparam int RESOLUTION = 4096;
    localparam int DATA_WIDTH = 32;
    localparam int N_WORDS    = RESOLUTION * (M + 1);
    localparam int ADDR_LSB   = 2;
    localparam int ADDR_WIDTH = $clog2(N_WORDS) + ADDR_LSB;
    localparam int CNT_WIDTH  = $clog2(N_WORDS + 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_DONE = 2'd2,
        ST_ERR  = 2'd3
    } ld_state_e;

endpackage : mp_pkg

// File: rtl/mp_coeff_loader_if.sv
// -----------------------------------------------------------------------------
// mp_coeff_loader_if
// AXI-Stream style coefficient stream feeding the MP LUT coefficient loader.
//   s_tdata_i  : coefficient word (I and Q packed)
//   s_tvalid_i : word valid
//   s_tlast_i  : last word of the frame
//   s_tready_o : loader ready
// Modports: master (stream source), slave (loader).
// -----------------------------------------------------------------------------
interface mp_coeff_loader_if #(
    parameter int DATA_WIDTH = mp_pkg::DATA_WIDTH
);

    logic [DATA_WIDTH-1:0] s_tdata_i;
    logic                  s_tvalid_i;
    logic                  s_tlast_i;
    logic                  s_tready_o;

    modport master (
        output s_tdata_i,
        output s_tvalid_i,
        output s_tlast_i,
        input  s_tready_o
    );

    modport slave (
        input  s_tdata_i,
        input  s_tvalid_i,
        input  s_tlast_i,
        output s_tready_o
    );

endinterface : mp_coeff_loader_if

// File: rtl/mp_coeff_loader.sv
// -----------------------------------------------------------------------------
// mp_coeff_loader
// Write-side initiator for the MP LUT coefficient port. Takes a frame of
// coefficient words from a stream and writes them to the LUT at sequential
// byte addresses, one write per accepted word with one cycle of latency.
// DPD is held bypassed while a load is in flight; frame length is checked
// against N_WORDS and completion/error are reported as sticky flags.
//
// Ports:
//   AXI_clk_i    : clock (only clock)
//   reset_n_i    : asynchronous active-low reset
//   start_i      : pulse, arms a new load (ignored while loading)
//   abort_i      : pulse, cancels a load in progress (wins over start_i)
//   dpd_en_i     : software DPD enable, honoured only after a good load
//   s_axis       : coefficient stream (slave modport)
//   coeff_o      : coefficient word to the LUT
//   coeff_addr_o : LUT byte address {word_index, 2'b00}
//   coeff_en_o   : LUT write strobe
//   wdpd_o       : DPD enable to the LUT wrapper
//   busy_o       : load in progress
//   done_o       : sticky, last load completed with correct length
//   err_o        : sticky, last load aborted or had a length/tlast error
//   word_cnt_o   : words accepted in the current/last load
// -----------------------------------------------------------------------------
module mp_coeff_loader
    import mp_pkg::*;
#(
    parameter int   M          = mp_pkg::M,
    parameter int   RESOLUTION = mp_pkg::RESOLUTION,
    parameter int   DATA_WIDTH = mp_pkg::DATA_WIDTH,
    localparam int  N_WORDS    = RESOLUTION * (M + 1),
    localparam int  IDX_WIDTH  = $clog2(N_WORDS),
    localparam int  ADDR_WIDTH = IDX_WIDTH + ADDR_LSB,
    localparam int  CNT_WIDTH  = $clog2(N_WORDS + 1)
) (
    input  logic                  AXI_clk_i,
    input  logic                  reset_n_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  dpd_en_i,
    mp_coeff_loader_if.slave      s_axis,
    output logic [DATA_WIDTH-1:0] coeff_o,
    output logic [ADDR_WIDTH-1:0] coeff_addr_o,
    output logic                  coeff_en_o,
    output logic                  wdpd_o,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic [CNT_WIDTH-1:0]  word_cnt_o
);

    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(N_WORDS - 1);

    ld_state_e             r_state;
    logic [IDX_WIDTH-1:0]  r_idx;
    logic [CNT_WIDTH-1:0]  r_word_cnt;
    logic                  r_tready;
    logic [DATA_WIDTH-1:0] r_coeff;
    logic [ADDR_WIDTH-1:0] r_coeff_addr;
    logic                  r_coeff_en;
    logic                  r_wdpd;
    logic                  r_busy;
    logic                  r_done;
    logic                  r_err;

    logic                  w_accept;
    logic                  w_last_idx;

    // r_tready is only ever high in LOAD, so an accept implies LOAD.
    assign w_accept   = s_axis.s_tvalid_i & r_tready;
    assign w_last_idx = (r_idx == LAST_IDX);

    // NOTE: all state lives in one clocked block with non-blocking
    // assignments, so every register sees the same pre-edge values and the
    // later assignment in program order wins where two branches touch one
    // register. Data registers (coeff/addr) are reset too: they are plain
    // flops, not a RAM, and resetting them costs nothing and keeps the
    // LUT port quiet out of reset.
    always_ff @(posedge AXI_clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            r_state      <= ST_IDLE;
            r_idx        <= '0;
            r_word_cnt   <= '0;
            r_tready     <= 1'b0;
            r_coeff      <= '0;
            r_coeff_addr <= '0;
            r_coeff_en   <= 1'b0;
            r_wdpd       <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            // Strobe is a single-cycle pulse per accepted word.
            r_coeff_en <= 1'b0;

            // Every accepted word reaches the LUT, including the one that
            // ends the load with an error, and one accepted in an abort cycle.
            if (w_accept) begin
                r_coeff_en   <= 1'b1;
                r_coeff      <= s_axis.s_tdata_i;
                r_coeff_addr <= {r_idx, {ADDR_LSB{1'b0}}};
                r_idx        <= r_idx + IDX_WIDTH'(1);
                r_word_cnt   <= r_word_cnt + CNT_WIDTH'(1);
            end

            unique case (r_state)
                ST_LOAD: begin
                    r_wdpd <= 1'b0;
                    if (abort_i) begin
                        r_state  <= ST_ERR;
                        r_tready <= 1'b0;
                        r_busy   <= 1'b0;
                        r_err    <= 1'b1;
                    end else if (w_accept && (w_last_idx || s_axis.s_tlast_i)) begin
                        // Only the final index carrying tlast is a good frame;
                        // early tlast and missing tlast both end in ERR. The
                        // index never advances past the last word because
                        // ready drops here.
                        r_tready <= 1'b0;
                        r_busy   <= 1'b0;
                        if (w_last_idx && s_axis.s_tlast_i) begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ST_ERR;
                            r_err   <= 1'b1;
                        end
                    end
                end

                default: begin
                    // IDLE, DONE and ERR: wait for start; abort is ignored.
                    if (start_i) begin
                        r_state    <= ST_LOAD;
                        r_tready   <= 1'b1;
                        r_busy     <= 1'b1;
                        r_idx      <= '0;
                        r_word_cnt <= '0;
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_wdpd     <= 1'b0;
                    end else begin
                        // DPD may only be enabled on top of a complete table.
                        r_wdpd <= (r_state == ST_DONE) ? dpd_en_i : 1'b0;
                    end
                end
            endcase
        end
    end

    assign s_axis.s_tready_o = r_tready;
    assign coeff_o           = r_coeff;
    assign coeff_addr_o      = r_coeff_addr;
    assign coeff_en_o        = r_coeff_en;
    assign wdpd_o            = r_wdpd;
    assign busy_o            = r_busy;
    assign done_o            = r_done;
    assign err_o             = r_err;
    assign word_cnt_o        = r_word_cnt;

endmodule : mp_coeff_loader

// File: tb/tb_mp_coeff_loader.sv
// -----------------------------------------------------------------------------
// tb_mp_coeff_loader
// Scoreboard bench for mp_coeff_loader. The driver pushes the expected LUT
// write (data, byte address) for every word it hands over; a monitor on the
// falling edge pops and compares on every coeff_en_o pulse. Status flags are
// checked at fixed points of each directed scenario.
// -----------------------------------------------------------------------------
module tb_mp_coeff_loader;
    import mp_pkg::*;

    localparam int NW = N_WORDS;
    localparam int AW = ADDR_WIDTH;
    localparam int CW = CNT_WIDTH;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0;
    logic abort = 1'b0;
    logic dpd_en = 1'b0;

    logic [DATA_WIDTH-1:0] coeff;
    logic [AW-1:0]         coeff_addr;
    logic                  coeff_en;
    logic                  wdpd;
    logic                  busy;
    logic                  done;
    logic                  err;
    logic [CW-1:0]         word_cnt;

    always #5 clk = ~clk;

    mp_coeff_loader_if #(.DATA_WIDTH(DATA_WIDTH)) s_if ();

    mp_coeff_loader dut (
        .AXI_clk_i   (clk),
        .reset_n_i   (rst_n),
        .start_i     (start),
        .abort_i     (abort),
        .dpd_en_i    (dpd_en),
        .s_axis      (s_if.slave),
        .coeff_o     (coeff),
        .coeff_addr_o(coeff_addr),
        .coeff_en_o  (coeff_en),
        .wdpd_o      (wdpd),
        .busy_o      (busy),
        .done_o      (done),
        .err_o       (err),
        .word_cnt_o  (word_cnt)
    );

    typedef struct {
        logic [31:0]   data;
        logic [AW-1:0] addr;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_total = 0;
    int  n_bad   = 0;
    int  cyc     = 0;
    int  n_wr    = 0;
    int  first_wr = 0;
    int  last_wr  = 0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_total++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Monitor: every LUT write must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && coeff_en === 1'b1) begin
            if (n_wr == 0) first_wr = cyc;
            last_wr = cyc;
            n_wr++;
            check("write_expected", 32'(exp_q.size() != 0), 32'd1);
            if (exp_q.size() != 0) begin
                mon_e = exp_q.pop_front();
                check("wr_data", coeff, mon_e.data);
                check("wr_addr", 32'(coeff_addr), 32'(mon_e.addr));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Present one word and wait (bounded) until the DUT takes it.
    task automatic send(input logic [31:0] d, input logic last, input int idx);
        int waited = 0;
        s_if.s_tdata_i  = d;
        s_if.s_tvalid_i = 1'b1;
        s_if.s_tlast_i  = last;
        while (s_if.s_tready_o !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        if (s_if.s_tready_o !== 1'b1) begin
            check("accept_timeout", 32'(waited), 32'd0);
        end else begin
            exp_q.push_back('{data: d, addr: AW'(idx) << ADDR_LSB});
            step();
        end
    endtask

    task automatic idle_stream();
        s_if.s_tvalid_i = 1'b0;
        s_if.s_tlast_i  = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish (t=%0t)", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        s_if.s_tdata_i  = '0;
        s_if.s_tvalid_i = 1'b0;
        s_if.s_tlast_i  = 1'b0;

        // ---------------- reset state ----------------
        #1;
        check("rst_tready", 32'(s_if.s_tready_o), 0);
        check("rst_en",     32'(coeff_en), 0);
        check("rst_wdpd",   32'(wdpd), 0);
        check("rst_busy",   32'(busy), 0);
        check("rst_done",   32'(done), 0);
        check("rst_err",    32'(err), 0);
        check("rst_cnt",    32'(word_cnt), 0);
        repeat (3) step();
        rst_n = 1'b1;
        step();

        // abort outside LOAD is ignored
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("idle_abort_err",  32'(err), 0);
        check("idle_abort_busy", 32'(busy), 0);

        // ---------------- nominal load with DPD gating ----------------
        dpd_en = 1'b1;
        n_wr   = 0;
        pulse_start();
        check("nom_busy",   32'(busy), 1);
        check("nom_tready", 32'(s_if.s_tready_o), 1);
        check("nom_wdpd0",  32'(wdpd), 0);
        check("nom_cnt0",   32'(word_cnt), 0);
        for (int i = 0; i < NW; i++) begin
            if (i == 8000) check("nom_wdpd_mid", 32'(wdpd), 0);
            send(32'(i), i == NW - 1, i);
        end
        idle_stream();
        check("nom_done",   32'(done), 1);
        check("nom_err",    32'(err), 0);
        check("nom_cnt",    32'(word_cnt), 32'(NW));
        check("nom_tready_drop", 32'(s_if.s_tready_o), 0);
        check("nom_busy_drop",   32'(busy), 0);
        check("nom_wdpd_at_done", 32'(wdpd), 0);
        step();
        check("nom_wdpd_on", 32'(wdpd), 1);
        check("nom_nwr",     32'(n_wr), 32'(NW));
        check("nom_span",    32'(last_wr - first_wr), 32'(NW - 1));

        // second start drops DPD and clears status
        pulse_start();
        check("re_wdpd", 32'(wdpd), 0);
        check("re_done", 32'(done), 0);
        check("re_cnt",  32'(word_cnt), 0);
        check("re_busy", 32'(busy), 1);

        // ---------------- early tlast on word 100 ----------------
        for (int i = 0; i <= 100; i++) send(32'hC0DE_0000 + 32'(i), i == 100, i);
        idle_stream();
        check("early_en",     32'(coeff_en), 1);
        check("early_addr",   32'(coeff_addr), 32'h190);
        check("early_data",   coeff, 32'hC0DE_0064);
        check("early_err",    32'(err), 1);
        check("early_done",   32'(done), 0);
        check("early_tready", 32'(s_if.s_tready_o), 0);
        check("early_wdpd",   32'(wdpd), 0);
        check("early_cnt",    32'(word_cnt), 101);
        dpd_en = 1'b0;

        // ---------------- missing tlast ----------------
        step();
        n_wr = 0;
        pulse_start();
        for (int i = 0; i < NW; i++) send(32'h5A00_0000 ^ 32'(i), 1'b0, i);
        idle_stream();
        check("miss_err",    32'(err), 1);
        check("miss_done",   32'(done), 0);
        check("miss_tready", 32'(s_if.s_tready_o), 0);
        check("miss_cnt",    32'(word_cnt), 32'(NW));
        // an extra word must not be taken or written
        s_if.s_tdata_i  = 32'hDEAD_BEEF;
        s_if.s_tvalid_i = 1'b1;
        s_if.s_tlast_i  = 1'b1;
        repeat (5) step();
        idle_stream();
        step();
        step();
        check("miss_nwr",        32'(n_wr), 32'(NW));
        check("miss_cnt_hold",   32'(word_cnt), 32'(NW));
        check("miss_tready_hold", 32'(s_if.s_tready_o), 0);

        // ---------------- gapped valid, start ignored, abort+start ----------------
        n_wr = 0;
        pulse_start();
        for (int i = 0; i < 50; i++) begin
            send(32'h1234_0000 + 32'(i), 1'b0, i);
            idle_stream();
            if (i == 20) start = 1'b1;
            if (i == 49) begin
                start = 1'b1;
                abort = 1'b1;
            end
            step();
            start = 1'b0;
            abort = 1'b0;
        end
        check("abort_err",    32'(err), 1);
        check("abort_done",   32'(done), 0);
        check("abort_tready", 32'(s_if.s_tready_o), 0);
        check("abort_busy",   32'(busy), 0);
        check("abort_cnt",    32'(word_cnt), 50);
        step();
        step();
        check("abort_nwr",    32'(n_wr), 50);

        // ---------------- asynchronous reset mid-load ----------------
        pulse_start();
        for (int i = 0; i < 30; i++) send(32'hA500_0000 + 32'(i), 1'b0, i);
        idle_stream();
        step();
        step();
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_busy",   32'(busy), 0);
        check("arst_tready", 32'(s_if.s_tready_o), 0);
        check("arst_cnt",    32'(word_cnt), 0);
        check("arst_coeff",  coeff, 0);
        check("arst_addr",   32'(coeff_addr), 0);
        check("arst_en",     32'(coeff_en), 0);
        check("arst_wdpd",   32'(wdpd), 0);
        check("arst_err",    32'(err), 0);
        #3;
        rst_n = 1'b1;
        step();
        check("post_rst_busy",   32'(busy), 0);
        check("post_rst_tready", 32'(s_if.s_tready_o), 0);
        check("post_rst_err",    32'(err), 0);
        pulse_start();
        check("post_rst_start_busy", 32'(busy), 1);
        abort = 1'b1;
        step();
        abort = 1'b0;
        check("post_rst_abort_err", 32'(err), 1);

        step();
        check("queue_drained", 32'(exp_q.size()), 0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule : tb_mp_coeff_loader
